bcd_calc_engine: RTL and testbench

// - Arithmetic stage downstream of the keypad front-end. Takes two 2-digit BCD operands
//   and an operator code, then computes add, subtract or multiply over several cycles.
// - Returns four display codes (BCD digits, blank, minus, error) that feed the 7-segment scanner.
// - Start/busy/done handshake; result held stable until the next accepted start.

---
 rtl/calc_codes.sv | 43 ++++
 rtl/bin2bcd_seq.sv | 56 +++++
 rtl/bcd_calc_engine.sv | 179 +++++++++++++++++
 tb/tb_bcd_calc_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_codes.sv
// Shared operator codes, display codes and FSM encoding for the calculator path.
package calc_codes;

    localparam int         BIN_W      = 14;

    localparam logic [3:0] OP_ADD     = 4'd10;
    localparam logic [3:0] OP_SUB     = 4'd11;
    localparam logic [3:0] OP_MUL     = 4'd12;

    localparam logic [3:0] CODE_MINUS = 4'd11;
    localparam logic [3:0] CODE_ERR   = 4'd14;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_CONV,
        S_FMT
    } state_e;

    // Two BCD digits to a 7-bit binary value (valid digits only).
    function automatic logic [6:0] bcd2_to_bin(input logic [3:0] tens, input logic [3:0] units);
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

    // Leading-zero blanking plus optional minus sign left of the most significant digit.
    function automatic logic [15:0] fmt_codes(input logic [15:0] bcd, input logic neg);
        logic [15:0] codes;
        int          msd;
        codes = bcd;
        msd   = 0;
        for (int i = 1; i < 4; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) msd = i;
        end
        for (int i = 1; i < 4; i++) begin
            if (i > msd) codes[i*4 +: 4] = CODE_BLANK;
        end
        if (neg && msd < 3) codes[(msd+1)*4 +: 4] = CODE_MINUS;
        return codes;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, BIN_W steps per conversion.
// done_o marks the final step; bcd_o then carries the finished digits combinationally.
module bin2bcd_seq
    import calc_codes::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             done_o,
    output logic [15:0]      bcd_o
);

    localparam logic [3:0] LAST_STEP = 4'(BIN_W - 1);

    logic [BIN_W-1:0] bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       cnt_q;
    logic             active_q;

    // One double-dabble step: correct digits >= 5, then shift the whole register left.
    always_comb begin
        logic [15:0] adj;
        // NOTE: every variable gets a value before any condition, so no latch is inferred.
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {adj, bin_q} << 1;
    end

    // Load on start, then step until the last bit has been shifted in.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            bin_q    <= bin_i;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == LAST_STEP) active_q <= 1'b0;
        end
    end

    assign done_o = active_q && (cnt_q == LAST_STEP);
    assign bcd_o  = bcd_d;

endmodule

// File: rtl/bcd_calc_engine.sv
// Multi-cycle BCD add/subtract/multiply producing four 7-segment display codes.
module bcd_calc_engine
    import calc_codes::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] opr,
    input  logic [3:0] add1,
    input  logic [3:0] add0,
    input  logic [3:0] aug1,
    input  logic [3:0] aug0,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] out3,
    output logic [3:0] out2,
    output logic [3:0] out1,
    output logic [3:0] out0
);

    localparam logic [15:0] OUT_RESET = {CODE_BLANK, CODE_BLANK, CODE_BLANK, 4'd0};

    state_e            state_q, state_d;
    logic [3:0]        opr_q, opr_d;
    logic [15:0]       dig_q, dig_d;
    logic [6:0]        a_q, a_d, b_q, b_d;
    logic              neg_q, neg_d;
    logic [BIN_W-1:0]  acc_q, acc_d, mcand_q, mcand_d;
    logic [6:0]        mplier_q, mplier_d;
    logic [2:0]        mcnt_q, mcnt_d;
    logic [15:0]       out_q, out_d;
    logic              err_q, err_d;

    logic              conv_start, conv_done;
    logic [BIN_W-1:0]  conv_bin;
    logic [15:0]       conv_bcd;
    logic [7:0]        sum, diff, diff_abs;
    logic              bad_input;

    assign sum      = {1'b0, a_q} + {1'b0, b_q};
    assign diff     = {1'b0, a_q} - {1'b0, b_q};
    assign diff_abs = diff[7] ? (8'd0 - diff) : diff;
    assign bad_input = (dig_q[15:12] > 4'd9) || (dig_q[11:8] > 4'd9) ||
                       (dig_q[7:4]   > 4'd9) || (dig_q[3:0]  > 4'd9) ||
                       !((opr_q == OP_ADD) || (opr_q == OP_SUB) || (opr_q == OP_MUL));

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (conv_start),
        .bin_i   (conv_bin),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Next-state and datapath control; the result registers load on the edge into FMT.
    always_comb begin
        state_d    = state_q;
        opr_d      = opr_q;
        dig_d      = dig_q;
        a_d        = a_q;
        b_d        = b_q;
        neg_d      = neg_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        mcnt_d     = mcnt_q;
        out_d      = out_q;
        err_d      = err_q;
        conv_start = 1'b0;
        conv_bin   = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opr_d   = opr;
                    dig_d   = {add1, add0, aug1, aug0};
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                a_d      = bcd2_to_bin(dig_q[15:12], dig_q[11:8]);
                b_d      = bcd2_to_bin(dig_q[7:4], dig_q[3:0]);
                acc_d    = '0;
                mcand_d  = {7'd0, a_d};
                mplier_d = b_d;
                mcnt_d   = '0;
                neg_d    = 1'b0;
                if (bad_input) begin
                    out_d   = {4{CODE_ERR}};
                    err_d   = 1'b1;
                    state_d = S_FMT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opr_q)
                    OP_ADD: begin
                        conv_bin   = {6'd0, sum};
                        conv_start = 1'b1;
                        state_d    = S_CONV;
                    end
                    OP_SUB: begin
                        conv_bin   = {6'd0, diff_abs};
                        neg_d      = diff[7];
                        conv_start = 1'b1;
                        state_d    = S_CONV;
                    end
                    OP_MUL: begin
                        if (mplier_q[0]) acc_d = acc_q + mcand_q;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        mcnt_d   = mcnt_q + 3'd1;
                        conv_bin = acc_d;
                        if (mcnt_q == 3'd6) begin
                            conv_start = 1'b1;
                            state_d    = S_CONV;
                        end
                    end
                    default: begin
                        out_d   = {4{CODE_ERR}};
                        err_d   = 1'b1;
                        state_d = S_FMT;
                    end
                endcase
            end
            S_CONV: begin
                if (conv_done) begin
                    out_d   = fmt_codes(conv_bcd, neg_q);
                    err_d   = 1'b0;
                    state_d = S_FMT;
                end
            end
            S_FMT: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opr_q    <= '0;
            dig_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            mcnt_q   <= '0;
            out_q    <= OUT_RESET;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opr_q    <= opr_d;
            dig_q    <= dig_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            mcnt_q   <= mcnt_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    assign busy = (state_q == S_LOAD) || (state_q == S_EXEC) || (state_q == S_CONV);
    assign done = (state_q == S_FMT);
    assign err  = err_q;
    assign {out3, out2, out1, out0} = out_q;

endmodule

// File: tb/tb_bcd_calc_engine.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor pops on done.
module tb_bcd_calc_engine;

    localparam logic [3:0] T_ADD = 4'd10;
    localparam logic [3:0] T_SUB = 4'd11;
    localparam logic [3:0] T_MUL = 4'd12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] opr = '0, add1 = '0, add0 = '0, aug1 = '0, aug0 = '0;
    logic       busy, done, err;
    logic [3:0] out3, out2, out1, out0;

    typedef struct {
        logic [15:0] codes;
        logic        err;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_start = 0;
    logic [15:0] hold_codes = 16'hFFF0;
    logic        hold_err = 1'b0;

    bcd_calc_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .opr   (opr),
        .add1  (add1),
        .add0  (add0),
        .aug1  (aug1),
        .aug0  (aug0),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .out3  (out3),
        .out2  (out2),
        .out1  (out1),
        .out0  (out0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain decimal arithmetic and digit counting.
    function automatic exp_t model(input logic [3:0] o, input logic [3:0] a1, input logic [3:0] a0,
                                   input logic [3:0] b1, input logic [3:0] b0, input int start_cyc);
        exp_t e;
        int   a, b, r, nd;
        bit   neg;
        int   d[4];
        neg = 0;
        r   = 0;
        if (a1 > 9 || a0 > 9 || b1 > 9 || b0 > 9 || !(o inside {T_ADD, T_SUB, T_MUL})) begin
            e.codes    = 16'hEEEE;
            e.err      = 1'b1;
            e.done_cyc = start_cyc + 2;
            return e;
        end
        a = int'(a1) * 10 + int'(a0);
        b = int'(b1) * 10 + int'(b0);
        if (o == T_ADD) r = a + b;
        else if (o == T_SUB) begin
            neg = (a < b);
            r   = neg ? b - a : a - b;
        end else r = a * b;
        d[0] = r % 10;
        d[1] = (r / 10) % 10;
        d[2] = (r / 100) % 10;
        d[3] = (r / 1000) % 10;
        nd = (r >= 1000) ? 4 : (r >= 100) ? 3 : (r >= 10) ? 2 : 1;
        for (int i = 0; i < 4; i++) e.codes[i*4 +: 4] = (i < nd) ? 4'(d[i]) : 4'hF;
        if (neg) e.codes[nd*4 +: 4] = 4'hB;
        e.err      = 1'b0;
        e.done_cyc = start_cyc + ((o == T_MUL) ? 23 : 17);
        return e;
    endfunction

    // Monitor: reset values while in reset, scoreboard compare on done, hold check otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_outs", {out3, out2, out1, out0}, 16'hFFF0);
            hold_codes = 16'hFFF0;
            hold_err   = 1'b0;
        end else if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("outs", {out3, out2, out1, out0}, e.codes);
                check("err", err, e.err);
                check("latency", cyc, e.done_cyc);
                check("busy_at_done", busy, 0);
                hold_codes = e.codes;
                hold_err   = e.err;
            end
        end else begin
            check("hold_outs", {out3, out2, out1, out0}, hold_codes);
            check("hold_err", err, hold_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic scramble();
        opr  = 4'($urandom);
        add1 = 4'($urandom);
        add0 = 4'($urandom);
        aug1 = 4'($urandom);
        aug0 = 4'($urandom);
    endtask

    task automatic issue(input logic [3:0] o, input logic [3:0] a1, input logic [3:0] a0,
                         input logic [3:0] b1, input logic [3:0] b0);
        drain();
        opr  = o;
        add1 = a1;
        add0 = a0;
        aug1 = b1;
        aug0 = b0;
        start = 1'b1;
        last_start = cyc;
        sb.push_back(model(o, a1, a0, b1, b0, cyc));
        tick();
        start = 1'b0;
        scramble();
        check("busy_after_start", busy, 1);
    endtask

    // A start pulse the DUT must ignore: nothing goes into the scoreboard.
    task automatic pulse_at(input int c);
        while (cyc < c) tick();
        opr  = 4'($urandom_range(10, 12));
        add1 = 4'($urandom_range(0, 9));
        add0 = 4'($urandom_range(0, 9));
        aug1 = 4'($urandom_range(0, 9));
        aug0 = 4'($urandom_range(0, 9));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [3:0] rand_digit();
        return ($urandom_range(0, 14) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    endfunction

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        issue(T_ADD, 4'd1, 4'd2, 4'd3, 4'd4);
        issue(T_SUB, 4'd0, 4'd7, 4'd5, 4'd2);
        issue(T_SUB, 4'd5, 4'd2, 4'd0, 4'd7);
        issue(T_MUL, 4'd9, 4'd9, 4'd9, 4'd9);
        issue(T_MUL, 4'd0, 4'd0, 4'd4, 4'd5);
        issue(4'd15, 4'd1, 4'd2, 4'd3, 4'd4);
        issue(T_ADD, 4'd1, 4'd12, 4'd3, 4'd4);
        issue(T_SUB, 4'd3, 4'd3, 4'd3, 4'd3);
        issue(T_SUB, 4'd0, 4'd0, 4'd9, 4'd9);

        // Starts during a multiply are ignored.
        issue(T_MUL, 4'd4, 4'd7, 4'd8, 4'd3);
        pulse_at(last_start + 5);
        pulse_at(last_start + 17);

        // Start in the done cycle is ignored.
        issue(T_ADD, 4'd5, 4'd5, 4'd4, 4'd4);
        pulse_at(last_start + 17);

        // Reset during the multiply loop aborts it without a done.
        issue(T_MUL, 4'd3, 4'd3, 4'd3, 4'd3);
        while (cyc < last_start + 5) tick();
        rst_n = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 40; n++) begin
            logic [3:0] o;
            o = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(10, 12));
            issue(o, rand_digit(), rand_digit(), rand_digit(), rand_digit());
            repeat ($urandom_range(0, 2)) tick();
        end

        drain();
        repeat (30) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
